mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 151 +++++++++++++++
 tb/tb_mult_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that time-shares one 32x32 multiplier among NUM_REQ
// requesters, with a per-operation timeout and a one-cycle response strobe.
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_id,
  output logic [63:0]            rsp_data,
  output logic                   rsp_err,
  output logic [31:0]            mult_multiplicand,
  output logic [31:0]            mult_multiplier,
  output logic                   mult_enable,
  input  logic [63:0]            mult_result,
  input  logic                   mult_done
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
  localparam logic [2:0]  LAST   = 3'(NUM_REQ - 1);

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  rsp_id_q, rsp_id_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic               any_req, found_hi;
  logic [2:0]         idx_hi, idx_lo, gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [31:0]        sel_a, sel_b;

  // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        idx_lo = 3'(j);
        if (3'(j) >= ptr_q) begin
          idx_hi   = 3'(j);
          found_hi = 1'b1;
        end
      end
    end
    any_req = |req_valid;
    gnt_idx = found_hi ? idx_hi : idx_lo;
    gnt_oh  = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (3'(j) == gnt_idx) begin
        gnt_oh[j] = any_req;
        sel_a     = req_a[32*j +: 32];
        sel_b     = req_b[32*j +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      rsp_id_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      rsp_id_q   <= rsp_id_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    rsp_id_d   = rsp_id_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_BUSY;
          idx_d   = gnt_idx;
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          cnt_d   = '0;
          ptr_d   = (gnt_idx == LAST) ? 3'd0 : gnt_idx + 3'd1;
        end
      end
      S_BUSY: begin
        if (mult_done) begin
          state_d    = S_RESP;
          rsp_data_d = mult_result;
          rsp_err_d  = 1'b0;
          rsp_id_d   = idx_q;
        end else begin
          // Saturating count; never wraps back below the limit.
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (cnt_d >= TO_LIM) begin
            state_d    = S_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            rsp_id_d   = idx_q;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant is combinational in IDLE; masked while reset is held.
  always_comb begin
    req_ready   = (state_q == S_IDLE && rst) ? gnt_oh : '0;
    mult_enable = (state_q == S_BUSY);
    rsp_valid   = (state_q == S_RESP);
  end

  assign rsp_id            = rsp_id_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_err           = rsp_err_q;
  assign mult_multiplicand = op_a_q;
  assign mult_multiplier   = op_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: a behavioural mult finishing after four
// enable cycles (or never, in hang mode) and hand-computed expected products.
module tb_mult_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid, rsp_err, mult_enable, mult_done;
  logic [2:0]      rsp_id;
  logic [63:0]     rsp_data, mult_result;
  logic [31:0]     mult_multiplicand, mult_multiplier;

  mult_arbiter #(.NUM_REQ(N), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mult_multiplicand(mult_multiplicand), .mult_multiplier(mult_multiplier),
    .mult_enable(mult_enable), .mult_result(mult_result), .mult_done(mult_done)
  );

  always #5 clk = ~clk;

  // mult model: done during the 4th consecutive enable cycle unless hung
  logic [2:0] m_cnt;
  logic       hang = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst)                  m_cnt <= 3'd0;
    else if (!mult_enable)     m_cnt <= 3'd0;
    else if (m_cnt != 3'd7)    m_cnt <= m_cnt + 3'd1;
  end
  assign mult_done   = mult_enable && (m_cnt == 3'd3) && !hang;
  assign mult_result = {32'd0, mult_multiplicand} * {32'd0, mult_multiplier};

  int          n_vec = 0, n_err = 0, cyc = 0;
  int          gq[$], gcyc[$], rid[$], rcyc[$], ren[$];
  logic [63:0] rdata[$];
  logic        rerr[$];
  int          en_run = 0, low_run = 0;
  bit          had_op = 1'b0;
  logic [31:0] exp_a = '0, exp_b = '0;
  logic [31:0] a_v[N], b_v[N];
  logic [N-1:0] persist = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample mid-cycle, then release accepted requesters after the edge.
  task automatic step();
    logic [N-1:0] clr;
    clr = '0;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a_v[i];
      req_b[32*i +: 32] = b_v[i];
    end
    @(negedge clk);
    cyc++;
    if (req_ready != '0) begin
      chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
      for (int i = 0; i < N; i++) if (req_ready[i]) begin
        gq.push_back(i); gcyc.push_back(cyc);
        exp_a = a_v[i]; exp_b = b_v[i];
        if (!persist[i]) clr[i] = 1'b1;
      end
    end
    if (mult_enable) begin
      if (en_run == 0 && had_op) chk("en_low_gap_ge2", 64'(low_run >= 2), 64'd1);
      en_run++; low_run = 0;
      chk("mult_a_stable", 64'(mult_multiplicand), 64'(exp_a));
      chk("mult_b_stable", 64'(mult_multiplier), 64'(exp_b));
    end else low_run++;
    if (rsp_valid) begin
      rid.push_back(int'(rsp_id)); rdata.push_back(rsp_data); rerr.push_back(rsp_err);
      rcyc.push_back(cyc); ren.push_back(en_run);
      en_run = 0; had_op = 1'b1;
    end
    @(posedge clk); #1;
    req_valid = req_valid & ~clr;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int b;
    b = budget;
    while (rid.size() < n && b > 0) begin step(); b--; end
    chk("rsp_count", 64'(rid.size()), 64'(n));
  endtask

  task automatic check_rsp(input int k, input int id, input logic [63:0] data, input logic err);
    if (k < rid.size()) begin
      chk("rsp_id", 64'(rid[k]), 64'(id));
      chk("rsp_data", rdata[k], data);
      chk("rsp_err", 64'(rerr[k]), 64'(err));
    end else chk("rsp_present", 64'(rid.size()), 64'(k + 1));
  endtask

  task automatic check_gnt(input int k, input int id);
    if (k < gq.size()) chk("grant_order", 64'(gq[k]), 64'(id));
    else chk("grant_present", 64'(gq.size()), 64'(k + 1));
  endtask

  // Asserts reset (possibly mid-operation), checks all outputs are zero, releases.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_mult_en", 64'(mult_enable), 64'd0);
    chk("rst_mult_a", 64'(mult_multiplicand), 64'd0);
    chk("rst_mult_b", 64'(mult_multiplier), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    gq.delete(); gcyc.delete(); rid.delete(); rdata.delete(); rerr.delete();
    rcyc.delete(); ren.delete();
    en_run = 0; low_run = 0; had_op = 1'b0;
  endtask

  initial begin
    int b;
    int base;
    req_valid = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '0; end

    // single request, pending during reset, granted on first edge after release
    a_v[0] = 32'd7; b_v[0] = 32'd5;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a_v[i];
      req_b[32*i +: 32] = b_v[i];
    end
    req_valid = 4'b0001;
    #3;
    @(posedge clk); #1;
    do_reset();
    wait_rsp(1, 40);
    chk("t1_grants", 64'(gq.size()), 64'd1);
    check_gnt(0, 0);
    check_rsp(0, 0, 64'd35, 1'b0);
    if (ren.size() > 0) chk("t1_enable_cycles", 64'(ren[0]), 64'd4);
    if (rcyc.size() > 0 && gcyc.size() > 0) chk("t1_latency", 64'(rcyc[0] - gcyc[0]), 64'd5);
    chk("t1_grant_cycle", 64'(gcyc.size() > 0 ? gcyc[0] : -1), 64'(cyc - 5));
    repeat (5) step();
    chk("t1_single_rsp", 64'(rid.size()), 64'd1);
    chk("t1_rsp_valid_low", 64'(rsp_valid), 64'd0);
    chk("t1_rsp_data_hold", rsp_data, 64'd35);

    // all four at once, from a fresh reset
    do_reset();
    a_v[0] = 32'd3;          b_v[0] = 32'd4;
    a_v[1] = 32'd100;        b_v[1] = 32'd200;
    a_v[2] = 32'h0001_0000;  b_v[2] = 32'h0001_0000;
    a_v[3] = 32'hFFFF_FFFF;  b_v[3] = 32'd2;
    req_valid = 4'b1111;
    wait_rsp(4, 100);
    for (int k = 0; k < 4; k++) check_gnt(k, k);
    check_rsp(0, 0, 64'd12, 1'b0);
    check_rsp(1, 1, 64'd20000, 1'b0);
    check_rsp(2, 2, 64'h0000_0001_0000_0000, 1'b0);
    check_rsp(3, 3, 64'h0000_0001_FFFF_FFFE, 1'b0);

    // fairness: 1 and 3 held valid
    do_reset();
    a_v[1] = 32'd21;   b_v[1] = 32'd2;
    a_v[3] = 32'd1000; b_v[3] = 32'd1000;
    persist = 4'b1010; req_valid = 4'b1010;
    b = 100;
    while (gq.size() < 4 && b > 0) begin step(); b--; end
    req_valid = '0; persist = '0;
    wait_rsp(4, 50);
    check_gnt(0, 1); check_gnt(1, 3); check_gnt(2, 1); check_gnt(3, 3);
    check_rsp(0, 1, 64'd42, 1'b0);
    check_rsp(1, 3, 64'd1000000, 1'b0);
    check_rsp(3, 3, 64'd1000000, 1'b0);

    // timeout then normal service
    hang = 1'b1;
    base = rid.size();
    a_v[2] = 32'd9; b_v[2] = 32'd9;
    req_valid = 4'b0100;
    wait_rsp(base + 1, 40);
    check_rsp(base, 2, 64'd0, 1'b1);
    if (ren.size() > base) chk("t4_busy_cycles", 64'(ren[base]), 64'd10);
    step();
    chk("t4_enable_dropped", 64'(mult_enable), 64'd0);
    hang = 1'b0;
    a_v[2] = 32'd6; b_v[2] = 32'd7;
    req_valid = 4'b0100;
    wait_rsp(base + 2, 40);
    check_rsp(base + 1, 2, 64'd42, 1'b0);
    if (ren.size() > base + 1) chk("t4_next_en_cycles", 64'(ren[base + 1]), 64'd4);

    // reset mid-BUSY, others pending; re-arbitrated from index 0
    base = gq.size();
    a_v[3] = 32'd11; b_v[3] = 32'd13;
    a_v[1] = 32'd5;  b_v[1] = 32'd5;
    req_valid = 4'b1000;
    b = 20;
    while (gq.size() == base && b > 0) begin step(); b--; end
    step(); step();
    req_valid = 4'b1010;
    step();
    chk("t5_no_grant_in_busy", 64'(gq.size()), 64'(base + 1));
    chk("t5_in_busy", 64'(mult_enable), 64'd1);
    #2;
    do_reset();
    wait_rsp(2, 60);
    check_gnt(0, 1); check_gnt(1, 3);
    check_rsp(0, 1, 64'd25, 1'b0);
    check_rsp(1, 3, 64'd143, 1'b0);

    // boundary operands
    base = rid.size();
    a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'hFFFF_FFFF;
    req_valid = 4'b0001;
    wait_rsp(base + 1, 40);
    check_rsp(base, 0, 64'hFFFF_FFFE_0000_0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
